// File: rtl/alu_scheduler_pkg.sv
// Shared constants, FSM encoding and op decode for the ALU scheduler.
package alu_scheduler_pkg;

  localparam logic [3:0] ALU_CTRL_NOP = 4'b0000;
  localparam logic [3:0] ALU_CTRL_ADD = 4'b0001;
  localparam logic [3:0] ALU_CTRL_MUL = 4'b0010;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic [3:0] op_to_ctrl(input logic op);
    return (op == OP_MUL) ? ALU_CTRL_MUL : ALU_CTRL_ADD;
  endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Requester and response channels of the ALU scheduler.
// Handshake: a transfer happens on the rising clock edge where valid and ready are both
// high; req_ready is a one-cycle accept pulse, resp_* stay stable while resp_valid waits for resp_ready.
interface alu_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_op;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [ID_W-1:0]      resp_id;
  logic [7:0]           resp_data;
  logic                 resp_timeout;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_timeout
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_timeout
  );
endinterface

// File: rtl/alu_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping at NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);
  localparam logic [ID_W:0] N_L = (ID_W+1)'(NUM_REQ);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
      if (w_sum >= N_L) w_sum = w_sum - N_L;
      w_cand = w_sum[ID_W-1:0];
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_scheduler.sv
// Shares one ALU among NUM_REQ requesters: round-robin grant, one op in flight,
// timeout on the ALU valid flag, single valid/ready response channel.
module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  alu_scheduler_if.slave     bus,
  output logic [7:0]         o_alu_a,
  output logic [7:0]         o_alu_b,
  output logic [3:0]         o_alu_ctrl,
  input  logic [7:0]         i_alu_y,
  input  logic               i_alu_valid,
  output state_t             o_state
);
  localparam logic [CNT_W-1:0] TIMEOUT_L = CNT_W'(TIMEOUT);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_req_ready, w_req_ready_nxt;
  logic [7:0]         r_alu_a, w_alu_a_nxt, r_alu_b, w_alu_b_nxt;
  logic [3:0]         r_alu_ctrl, w_alu_ctrl_nxt;
  logic [ID_W-1:0]    r_grant, w_grant_nxt, r_ptr, w_ptr_nxt, r_resp_id, w_resp_id_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_resp_valid, w_resp_valid_nxt, r_resp_timeout, w_resp_timeout_nxt;
  logic [7:0]         r_resp_data, w_resp_data_nxt;

  logic [NUM_REQ-1:0] w_arb_grant;
  logic [ID_W-1:0]    w_arb_idx;
  logic               w_arb_any;
  logic [7:0]         w_sel_a, w_sel_b;
  logic               w_sel_op;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = OP_ADD;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_grant[i]) begin
        w_sel_a  = bus.req_a[8*i +: 8];
        w_sel_b  = bus.req_b[8*i +: 8];
        w_sel_op = bus.req_op[i];
      end
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_req_ready_nxt    = '0;
    w_alu_a_nxt        = r_alu_a;
    w_alu_b_nxt        = r_alu_b;
    w_alu_ctrl_nxt     = r_alu_ctrl;
    w_grant_nxt        = r_grant;
    w_ptr_nxt          = r_ptr;
    w_cnt_nxt          = r_cnt;
    w_resp_valid_nxt   = r_resp_valid;
    w_resp_id_nxt      = r_resp_id;
    w_resp_data_nxt    = r_resp_data;
    w_resp_timeout_nxt = r_resp_timeout;
    case (r_state)
      ST_IDLE: begin
        w_alu_ctrl_nxt = ALU_CTRL_NOP;
        if (w_arb_any) begin
          w_req_ready_nxt = w_arb_grant;
          w_alu_a_nxt     = w_sel_a;
          w_alu_b_nxt     = w_sel_b;
          w_alu_ctrl_nxt  = op_to_ctrl(w_sel_op);
          w_grant_nxt     = w_arb_idx;
          w_state_nxt     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // alu_valid is not looked at here: it may still reflect the previous op.
        w_cnt_nxt   = '0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (i_alu_valid) begin
          w_resp_data_nxt    = i_alu_y;
          w_resp_timeout_nxt = 1'b0;
          w_resp_valid_nxt   = 1'b1;
          w_resp_id_nxt      = r_grant;
          w_alu_ctrl_nxt     = ALU_CTRL_NOP;
          w_state_nxt        = ST_RESP;
        end else if (r_cnt + CNT_W'(1) == TIMEOUT_L) begin
          w_resp_data_nxt    = '0;
          w_resp_timeout_nxt = 1'b1;
          w_resp_valid_nxt   = 1'b1;
          w_resp_id_nxt      = r_grant;
          w_alu_ctrl_nxt     = ALU_CTRL_NOP;
          w_state_nxt        = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          w_resp_valid_nxt = 1'b0;
          w_ptr_nxt        = (r_grant == LAST_ID) ? '0 : r_grant + ID_W'(1);
          w_state_nxt      = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_req_ready    <= '0;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_ctrl     <= ALU_CTRL_NOP;
      r_grant        <= '0;
      r_ptr          <= '0;
      r_cnt          <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_id      <= '0;
      r_resp_data    <= '0;
      r_resp_timeout <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_req_ready    <= w_req_ready_nxt;
      r_alu_a        <= w_alu_a_nxt;
      r_alu_b        <= w_alu_b_nxt;
      r_alu_ctrl     <= w_alu_ctrl_nxt;
      r_grant        <= w_grant_nxt;
      r_ptr          <= w_ptr_nxt;
      r_cnt          <= w_cnt_nxt;
      r_resp_valid   <= w_resp_valid_nxt;
      r_resp_id      <= w_resp_id_nxt;
      r_resp_data    <= w_resp_data_nxt;
      r_resp_timeout <= w_resp_timeout_nxt;
    end
  end

  assign bus.req_ready    = r_req_ready;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_id      = r_resp_id;
  assign bus.resp_data    = r_resp_data;
  assign bus.resp_timeout = r_resp_timeout;
  assign o_alu_a          = r_alu_a;
  assign o_alu_b          = r_alu_b;
  assign o_alu_ctrl       = r_alu_ctrl;
  assign o_state          = r_state;
endmodule
